// File: rtl/scc_8530.sv
// scc_8530: Z8530-style dual-channel SCC, register-compatible subset.
// Channel A carries an 8N1 UART on rxd/txd; channel B has registers and
// DCD ext/status interrupts only. Channel index 1 = A, 0 = B throughout.
// Optional build macro SCC_LOOPBACK_EN: WR14A[4] loops A's tx into its rx.
module scc_8530 #(
    parameter int CLK_PER_BIT = 124
) (
    input  logic       clk,
    input  logic       reset_hw,
    input  logic       cep,
    input  logic       cen,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] rs,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       _irq,
    input  logic       rxd,
    output logic       txd,
    input  logic       cts,
    output logic       rts,
    input  logic       dcd_a,
    input  logic       dcd_b,
    output logic       wreq
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

    logic [3:0]    r_ptr;
    logic [7:0]    r_wr2, r_wr9;
    logic [7:0]    r_wr1 [2], r_wr3 [2], r_wr4 [2], r_wr5 [2];
    logic [7:0]    r_wr10 [2], r_wr11 [2], r_wr12 [2], r_wr13 [2], r_wr14 [2], r_wr15 [2];
    logic [1:0]    r_dcd_s1, r_dcd_s2, r_dcd_d, r_ip_ext;
    logic          r_cts_s1, r_cts_s2, r_rx_s1, r_rx_s2, r_rx_s3;
    logic          r_ip_tx, r_ip_rx, r_rx_avail, r_tx_full, r_irq_n;
    logic [7:0]    r_tbuf, r_rr8;
    logic          r_tx_busy;
    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bits;
    rx_st_t        r_rx_st, w_rx_st;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt;
    logic [2:0]    r_rx_bit, w_rx_bit;
    logic [7:0]    r_rx_sh, w_rx_sh;
    logic          w_rx_done;

    logic w_acc, w_ch, w_ctl_wr, w_ctl_rd, w_dat_wr, w_dat_rd, w_wr0, w_wrn, w_wr9;
    logic w_rst_all, w_rst_a, w_rst_b, w_tx_load, w_tx_line, w_rx_in, w_unused;
    logic [1:0] w_rst_ch, w_ext_set, w_ext_clr;
    logic [2:0] w_code;

    // Bus decode; resets issued through WR9 act in the same cycle as reset_hw
    assign w_acc     = cs && cen;
    assign w_ch      = rs[0];
    assign w_ctl_wr  = w_acc && we && !rs[1];
    assign w_ctl_rd  = w_acc && !we && !rs[1];
    assign w_dat_wr  = w_acc && we && rs[1];
    assign w_dat_rd  = w_acc && !we && rs[1];
    assign w_wr0     = w_ctl_wr && (r_ptr == 4'd0);
    assign w_wrn     = w_ctl_wr && (r_ptr != 4'd0);
    assign w_wr9     = w_wrn && (r_ptr == 4'd9);
    assign w_rst_all = reset_hw || (w_wr9 && wdata[7:6] == 2'b11);
    assign w_rst_a   = w_rst_all || (w_wr9 && wdata[7:6] == 2'b10);
    assign w_rst_b   = w_rst_all || (w_wr9 && wdata[7:6] == 2'b01);
    assign w_rst_ch  = {w_rst_a, w_rst_b};

    // Pointer and shared registers
    always_ff @(posedge clk) begin
        if (w_rst_all) begin
            r_ptr <= 4'd0;
            r_wr2 <= '0;
            r_wr9 <= '0;
        end else begin
            if (w_wr0)
                r_ptr <= {wdata[5:3] == 3'b001, wdata[2:0]};
            else if ((w_ctl_wr || w_ctl_rd) && r_ptr != 4'd0)
                r_ptr <= 4'd0;
            if (w_wrn && r_ptr == 4'd2) r_wr2 <= wdata;
            if (w_wr9) r_wr9 <= wdata;
        end
    end

    // Per-channel write registers
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (w_rst_ch[c]) begin
                r_wr1[c]  <= '0; r_wr3[c]  <= '0; r_wr4[c]  <= '0; r_wr5[c]  <= '0;
                r_wr10[c] <= '0; r_wr11[c] <= '0; r_wr12[c] <= '0; r_wr13[c] <= '0;
                r_wr14[c] <= '0; r_wr15[c] <= '0;
            end else if (w_wrn && (w_ch == (c == 1))) begin
                case (r_ptr)
                    4'd1:    r_wr1[c]  <= wdata;
                    4'd3:    r_wr3[c]  <= wdata;
                    4'd4:    r_wr4[c]  <= wdata;
                    4'd5:    r_wr5[c]  <= wdata;
                    4'd10:   r_wr10[c] <= wdata;
                    4'd11:   r_wr11[c] <= wdata;
                    4'd12:   r_wr12[c] <= wdata;
                    4'd13:   r_wr13[c] <= wdata;
                    4'd14:   r_wr14[c] <= wdata;
                    4'd15:   r_wr15[c] <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Input synchronisers; left unreset so reset never fakes a DCD/start edge
    always_ff @(posedge clk) begin
        r_dcd_s1 <= {dcd_a, dcd_b};
        r_dcd_s2 <= r_dcd_s1;
        r_dcd_d  <= r_dcd_s2;
        r_cts_s1 <= cts;
        r_cts_s2 <= r_cts_s1;
        r_rx_s1  <= w_rx_in;
        r_rx_s2  <= r_rx_s1;
        r_rx_s3  <= r_rx_s2;
    end

    assign w_ext_set[1] = (r_dcd_s2[1] ^ r_dcd_d[1]) && r_wr15[1][3] && r_wr1[1][0];
    assign w_ext_set[0] = (r_dcd_s2[0] ^ r_dcd_d[0]) && r_wr15[0][3] && r_wr1[0][0];
    assign w_ext_clr[1] = w_wr0 && w_ch && (wdata[5:3] == 3'b010);
    assign w_ext_clr[0] = w_wr0 && !w_ch && (wdata[5:3] == 3'b010);

    // Ext/status pending bits; a DCD edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (w_rst_ch[c])       r_ip_ext[c] <= 1'b0;
            else if (w_ext_set[c]) r_ip_ext[c] <= 1'b1;
            else if (w_ext_clr[c]) r_ip_ext[c] <= 1'b0;
        end
    end

    assign w_tx_load = r_tx_full && !r_tx_busy && r_wr5[1][3];

    // Channel A tx buffer, rx holding register and their pending bits
    always_ff @(posedge clk) begin
        if (w_rst_a) begin
            r_tbuf <= '0; r_tx_full <= 1'b0; r_ip_tx <= 1'b0;
            r_rr8  <= '0; r_rx_avail <= 1'b0; r_ip_rx <= 1'b0;
        end else begin
            if (w_dat_wr && w_ch) begin
                r_tbuf    <= wdata;
                r_tx_full <= 1'b1;
                r_ip_tx   <= 1'b0;
            end else begin
                if (w_wr0 && w_ch && wdata[5:3] == 3'b101) r_ip_tx <= 1'b0;
                if (w_tx_load) begin
                    r_tx_full <= 1'b0;
                    if (r_wr1[1][1]) r_ip_tx <= 1'b1;
                end
            end
            if (w_dat_rd && w_ch) begin
                r_rx_avail <= 1'b0;
                r_ip_rx    <= 1'b0;
            end
            if (w_rx_done) begin
                r_rr8      <= r_rx_sh;
                r_rx_avail <= 1'b1;
                if (r_wr1[1][4:3] != 2'b00) r_ip_rx <= 1'b1;
            end
        end
    end

    // Tx shifter: {stop, data, start} shifted LSB first, filled with idle 1s
    always_ff @(posedge clk) begin
        if (w_rst_a) begin
            r_tx_busy <= 1'b0; r_tx_sh <= '1; r_tx_cnt <= '0; r_tx_bits <= '0;
        end else if (w_tx_load) begin
            r_tx_busy <= 1'b1;
            r_tx_sh   <= {1'b1, r_tbuf, 1'b0};
            r_tx_cnt  <= '0;
            r_tx_bits <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == C_LAST) begin
                r_tx_cnt  <= '0;
                r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
                r_tx_bits <= r_tx_bits + 4'd1;
                if (r_tx_bits == 4'd9) r_tx_busy <= 1'b0;
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign w_tx_line = r_tx_sh[0];
`ifdef SCC_LOOPBACK_EN
    assign w_rx_in = r_wr14[1][4] ? w_tx_line : rxd;
    assign txd     = r_wr14[1][4] ? 1'b1 : w_tx_line;
`else
    assign w_rx_in = rxd;
    assign txd     = w_tx_line;
`endif

    // Receiver state register
    always_ff @(posedge clk) begin
        if (w_rst_a) begin
            r_rx_st <= RX_IDLE; r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_sh <= '0;
        end else begin
            r_rx_st <= w_rx_st; r_rx_cnt <= w_rx_cnt; r_rx_bit <= w_rx_bit; r_rx_sh <= w_rx_sh;
        end
    end

    // Receiver next state: half-bit to mid start, then full bits to mid data/stop
    always_comb begin
        w_rx_st   = r_rx_st;
        w_rx_cnt  = r_rx_cnt + 1'b1;
        w_rx_bit  = r_rx_bit;
        w_rx_sh   = r_rx_sh;
        w_rx_done = 1'b0;
        case (r_rx_st)
            RX_IDLE: begin
                w_rx_cnt = '0;
                if (r_wr3[1][0] && r_rx_s3 && !r_rx_s2) w_rx_st = RX_START;
            end
            RX_START: if (r_rx_cnt == C_HALF) begin
                w_rx_cnt = '0;
                w_rx_bit = '0;
                w_rx_st  = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_rx_cnt == C_LAST) begin
                w_rx_cnt = '0;
                w_rx_sh  = {r_rx_s2, r_rx_sh[7:1]};
                w_rx_bit = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_st = RX_STOP;
            end
            RX_STOP: if (r_rx_cnt == C_LAST) begin
                w_rx_cnt  = '0;
                w_rx_st   = RX_IDLE;
                w_rx_done = r_rx_s2;
            end
            default: w_rx_st = RX_IDLE;
        endcase
    end

    // Highest pending interrupt code for RR2B
    always_comb begin
        w_code = 3'b011;
        if (r_ip_rx)          w_code = 3'b110;
        else if (r_ip_tx)     w_code = 3'b100;
        else if (r_ip_ext[1]) w_code = 3'b101;
        else if (r_ip_ext[0]) w_code = 3'b001;
    end

    // Read mux
    always_comb begin
        rdata = 8'h00;
        if (rs[1]) begin
            rdata = w_ch ? r_rr8 : 8'h00;
        end else begin
            case (r_ptr)
                4'd0:    rdata = w_ch ? {2'b00, r_cts_s2, 1'b0, r_dcd_s2[1], !r_tx_full, 1'b0, r_rx_avail}
                                      : {2'b00, 1'b1, 1'b0, r_dcd_s2[0], 1'b1, 2'b00};
                4'd1:    rdata = 8'h01;
                4'd2:    rdata = w_ch ? r_wr2 : {r_wr2[7:4], w_code, r_wr2[0]};
                4'd3:    rdata = w_ch ? {2'b00, r_ip_rx, r_ip_tx, r_ip_ext[1], 2'b00, r_ip_ext[0]} : 8'h00;
                4'd12:   rdata = r_wr12[w_ch];
                4'd13:   rdata = r_wr13[w_ch];
                4'd15:   rdata = r_wr15[w_ch];
                default: rdata = 8'h00;
            endcase
        end
    end

    // Registered interrupt line
    always_ff @(posedge clk) begin
        if (w_rst_all) r_irq_n <= 1'b1;
        else           r_irq_n <= !(r_wr9[3] && (r_ip_rx || r_ip_tx || (|r_ip_ext)));
    end

    assign _irq = r_irq_n;
    assign rts  = !r_wr5[1][1];
    assign wreq = r_wr1[1][7] && (r_wr1[1][5] ? r_rx_avail : !r_tx_full);

    // Stored-only register bits and the unused bus phase
    assign w_unused = ^{cep, r_wr1[0], r_wr1[1], r_wr3[0], r_wr3[1], r_wr4[0], r_wr4[1],
                        r_wr5[0], r_wr5[1], r_wr10[0], r_wr10[1], r_wr11[0], r_wr11[1],
                        r_wr14[0], r_wr14[1], r_wr15[0], r_wr15[1], r_wr9};
endmodule

// File: tb/tb_scc_8530.sv
// tb_scc_8530: directed bench for scc_8530 with hand-computed expectations.
module tb_scc_8530;
    localparam int CPB = 124;
    localparam logic [1:0] CB = 2'b00, CA = 2'b01, DB = 2'b10, DA = 2'b11;

    logic       clk = 1'b0, reset_hw = 1'b1, cep = 1'b0, cen = 1'b1, cs = 1'b0, we = 1'b0;
    logic [1:0] rs = 2'b00;
    logic [7:0] wdata = 8'h00, rdata;
    logic       irq_n, rxd = 1'b1, txd, cts = 1'b1, rts, dcd_a = 1'b1, dcd_b = 1'b1, wreq;
    int         n_chk = 0, n_fail = 0;

    scc_8530 #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .reset_hw(reset_hw), .cep(cep), .cen(cen), .cs(cs), .we(we), .rs(rs),
        .wdata(wdata), .rdata(rdata), ._irq(irq_n), .rxd(rxd), .txd(txd), .cts(cts),
        .rts(rts), .dcd_a(dcd_a), .dcd_b(dcd_b), .wreq(wreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; rs = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        @(negedge clk);
        cs = 1'b1; we = 1'b0; rs = a;
        #1 d = rdata;
        @(negedge clk);
        cs = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            ticks(CPB);
        end
        rxd = 1'b1;
    endtask

    initial begin
        logic [9:0] frame;
        ticks(5);
        reset_hw = 1'b0;
        ticks(2);
        chk("irq_rst", irq_n, 1);
        chk("txd_rst", txd, 1);
        chk("rts_rst", rts, 1);
        chk("wreq_rst", wreq, 0);
        rd_chk("rr0a_rst", CA, 8'h2C);

        // pointer: WR12B via point-high, echo, then back at RR0
        bus_wr(CB, 8'h0C); bus_wr(CB, 8'h5A);
        bus_wr(CB, 8'h0C);
        rd_chk("rr12b", CB, 8'h5A);
        rd_chk("rr0b_ptr0", CB, 8'h2C);
        bus_wr(CA, 8'h0C);
        rd_chk("rr12a_sep", CA, 8'h00);

        // ext/status on channel B
        bus_wr(CB, 8'h01); bus_wr(CB, 8'h01);
        bus_wr(CB, 8'h0F); bus_wr(CB, 8'h08);
        bus_wr(CB, 8'h09); bus_wr(CB, 8'h08);
        dcd_a = 1'b0; ticks(6);
        chk("irq_dcda_masked", irq_n, 1);
        dcd_a = 1'b1; ticks(6);
        chk("irq_dcda_masked2", irq_n, 1);
        dcd_b = 1'b0; ticks(6);
        chk("irq_extb", irq_n, 0);
        bus_wr(CA, 8'h03);
        rd_chk("rr3a_extb", CA, 8'h01);
        bus_wr(CB, 8'h02);
        rd_chk("rr2b_extb", CB, 8'h02);
        bus_wr(CB, 8'h10); ticks(3);
        chk("irq_extb_clr", irq_n, 1);
        bus_wr(CA, 8'h03);
        rd_chk("rr3a_clr", CA, 8'h00);

        // channel A transmit of 0x55
        bus_wr(CA, 8'h05); bus_wr(CA, 8'h08);
        bus_wr(CA, 8'h01); bus_wr(CA, 8'h02);
        bus_wr(DA, 8'h55);
        frame = {1'b1, 8'h55, 1'b0};
        ticks(62);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("txd_bit%0d", k), txd, frame[k]);
            if (k < 9) ticks(CPB);
        end
        ticks(70);
        chk("txd_idle", txd, 1);
        chk("irq_tx", irq_n, 0);
        bus_wr(CA, 8'h03);
        rd_chk("rr3a_tx", CA, 8'h10);
        bus_wr(CB, 8'h02);
        rd_chk("rr2b_tx", CB, 8'h08);
        bus_wr(CA, 8'h28); ticks(3);
        chk("irq_tx_clr", irq_n, 1);
        bus_wr(CA, 8'h01); bus_wr(CA, 8'h82);
        chk("wreq_txempty", wreq, 1);
        bus_wr(CA, 8'h05); bus_wr(CA, 8'h0A);
        chk("rts_on", rts, 0);

        // channel A receive of 0xA3, wreq follows char available
        bus_wr(CA, 8'h03); bus_wr(CA, 8'h01);
        bus_wr(CA, 8'h01); bus_wr(CA, 8'hB0);
        chk("wreq_noavail", wreq, 0);
        send_rx(8'hA3);
        ticks(10);
        rd_chk("rr0a_avail", CA, 8'h2D);
        chk("irq_rx", irq_n, 0);
        chk("wreq_avail", wreq, 1);
        bus_wr(CA, 8'h03);
        rd_chk("rr3a_rx", CA, 8'h20);
        bus_wr(CB, 8'h02);
        rd_chk("rr2b_rx", CB, 8'h0C);
        rd_chk("rr8a", DA, 8'hA3);
        rd_chk("rr0a_empty", CA, 8'h2C);
        ticks(2);
        chk("irq_rx_clr", irq_n, 1);
        chk("wreq_cleared", wreq, 0);

        // full reset through WR9 in the middle of a frame
        bus_wr(DA, 8'h00);
        ticks(200);
        chk("txd_midframe", txd, 0);
        bus_wr(CA, 8'h09); bus_wr(CA, 8'hC0);
        chk("txd_after_rst", txd, 1);
        chk("rts_after_rst", rts, 1);
        chk("irq_after_rst", irq_n, 1);
        chk("wreq_after_rst", wreq, 0);
        rd_chk("rr0a_after_rst", CA, 8'h2C);
        bus_wr(CB, 8'h0C);
        rd_chk("rr12b_after_rst", CB, 8'h00);
        rd_chk("rr8a_after_rst", DA, 8'h00);
        ticks(CPB * 2);
        chk("txd_stays_idle", txd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
